flags_sequencer: RTL and testbench

Multi-cycle write-side controller for the architectural flags register. It turns flag-manipulating microcode commands into `flags_in`/`update_flags` write pulses for the flags register:
- interrupt/trap entry (save, then clear IF/TF),
- POPF/IRET restore,
- CLI/STI/CLD/STD/CLC/STC/CMC.

It also tracks the single-step trap and the STI interrupt shadow. It sits between the microcode sequencer and the flags register, and reads back the register's `flags_out`.

---
 rtl/flags_sequencer_pkg.sv | 46 ++++
 rtl/flags_sequencer_if.sv | 33 +++
 rtl/flags_sequencer_trap_tracker.sv | 57 +++++
 rtl/flags_sequencer.sv | 114 +++++++++++
 tb/tb_flags_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flags_sequencer_pkg.sv
// Shared definitions for the flags register write side: command codes,
// architectural flag bit positions and the per-flag update mask order.
package flags_sequencer_pkg;

  typedef enum logic [3:0] {
    CMD_ENTRY   = 4'd0,
    CMD_RESTORE = 4'd1,
    CMD_CLI     = 4'd2,
    CMD_STI     = 4'd3,
    CMD_CLD     = 4'd4,
    CMD_STD     = 4'd5,
    CMD_CLC     = 4'd6,
    CMD_STC     = 4'd7,
    CMD_CMC     = 4'd8
  } FlagsCmd;

  typedef enum int unsigned {
    UF_CF = 0,
    UF_PF = 1,
    UF_AF = 2,
    UF_ZF = 3,
    UF_SF = 4,
    UF_TF = 5,
    UF_IF = 6,
    UF_DF = 7,
    UF_OF = 8
  } UpdateFlags;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_TF = 8;
  localparam int FLAG_IF = 9;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  function automatic logic [8:0] ufMask(input UpdateFlags f);
    logic [8:0] m;
    m    = '0;
    m[f] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/flags_sequencer_if.sv
// Command, flags-register and trap signals between the microcode sequencer
// (master) and the flags sequencer (slave).
interface flags_sequencer_if;
  import flags_sequencer_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  FlagsCmd     cmd;
  logic [15:0] cmd_data;
  logic [15:0] flags_cur;
  logic [15:0] flags_in;
  logic [8:0]  update_flags;
  logic [15:0] saved_flags;
  logic        saved_valid;
  logic        done;
  logic        instr_done;
  logic        trap_pending;
  logic        trap_ack;
  logic        int_inhibit;

  modport master (
    output cmd_valid, cmd, cmd_data, flags_cur, instr_done, trap_ack,
    input  cmd_ready, flags_in, update_flags, saved_flags, saved_valid,
           done, trap_pending, int_inhibit
  );

  modport slave (
    input  cmd_valid, cmd, cmd_data, flags_cur, instr_done, trap_ack,
    output cmd_ready, flags_in, update_flags, saved_flags, saved_valid,
           done, trap_pending, int_inhibit
  );

endinterface

// File: rtl/flags_sequencer_trap_tracker.sv
// Single-step trap request and STI interrupt-shadow tracking, advanced by
// instruction retirement.
module trap_tracker
  import flags_sequencer_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic entry_clr_i,
  input  logic tf_arm_i,
  input  logic sti_set_i,
  input  logic instr_done_i,
  input  logic trap_ack_i,
  input  logic tf_cur_i,
  output logic trap_pending_o,
  output logic int_inhibit_o
);

  logic tf_shadow_q, tf_shadow_d;
  logic trap_q, trap_d;
  logic inhibit_q, inhibit_d;

  // Later assignments take priority: a trap set beats a same-cycle ack,
  // and accepting ENTRY discards any pending single-step state.
  always_comb begin
    tf_shadow_d = tf_shadow_q;
    trap_d      = trap_q;
    inhibit_d   = inhibit_q;
    if (trap_ack_i) trap_d = 1'b0;
    if (instr_done_i) begin
      inhibit_d = 1'b0;
      if (tf_shadow_q) tf_shadow_d = 1'b0;
      else if (tf_cur_i) trap_d = 1'b1;
    end
    if (tf_arm_i) tf_shadow_d = 1'b1;
    if (sti_set_i) inhibit_d = 1'b1;
    if (entry_clr_i) begin
      trap_d      = 1'b0;
      tf_shadow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tf_shadow_q <= 1'b0;
      trap_q      <= 1'b0;
      inhibit_q   <= 1'b0;
    end else begin
      tf_shadow_q <= tf_shadow_d;
      trap_q      <= trap_d;
      inhibit_q   <= inhibit_d;
    end
  end

  assign trap_pending_o = trap_q;
  assign int_inhibit_o  = inhibit_q;

endmodule

// File: rtl/flags_sequencer.sv
// Turns flag-manipulating microcode commands into flags-register write
// pulses: trap entry save/clear, POPF/IRET restore and single-flag ops.
module flags_sequencer
  import flags_sequencer_pkg::*;
#(
  parameter logic [15:0] FLAGS_RESET = 16'h0002
)
(
  input logic              clk,
  input logic              reset_n,
  flags_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SAVE  = 2'd1;
  localparam logic [1:0] ST_CLR   = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  logic [1:0]  state_q, state_d;
  FlagsCmd     cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic [15:0] saved_q, saved_d;
  logic        accept;
  logic [8:0]  mask;
  logic [15:0] fin;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    saved_d = saved_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d   = bus.cmd;
          data_d  = bus.cmd_data;
          state_d = (bus.cmd == CMD_ENTRY) ? ST_SAVE : ST_WRITE;
        end
      end
      ST_SAVE: begin
        saved_d = bus.flags_cur;
        state_d = ST_CLR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_ENTRY;
      data_q  <= '0;
      saved_q <= FLAGS_RESET;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      saved_q <= saved_d;
    end
  end

  // Single-flag ops rewrite only their bit; CMC reads CF live in the write cycle.
  always_comb begin
    mask = '0;
    fin  = '0;
    if (state_q == ST_CLR) begin
      mask          = ufMask(UF_TF) | ufMask(UF_IF);
      fin           = bus.flags_cur;
      fin[FLAG_TF]  = 1'b0;
      fin[FLAG_IF]  = 1'b0;
    end else if (state_q == ST_WRITE) begin
      fin = bus.flags_cur;
      case (cmd_q)
        CMD_RESTORE: begin
          mask = '1;
          fin  = data_q | FLAGS_RESET;
        end
        CMD_CLI: begin mask = ufMask(UF_IF); fin[FLAG_IF] = 1'b0; end
        CMD_STI: begin mask = ufMask(UF_IF); fin[FLAG_IF] = 1'b1; end
        CMD_CLD: begin mask = ufMask(UF_DF); fin[FLAG_DF] = 1'b0; end
        CMD_STD: begin mask = ufMask(UF_DF); fin[FLAG_DF] = 1'b1; end
        CMD_CLC: begin mask = ufMask(UF_CF); fin[FLAG_CF] = 1'b0; end
        CMD_STC: begin mask = ufMask(UF_CF); fin[FLAG_CF] = 1'b1; end
        CMD_CMC: begin mask = ufMask(UF_CF); fin[FLAG_CF] = ~bus.flags_cur[FLAG_CF]; end
        default: begin mask = '0; fin = '0; end
      endcase
    end
  end

  assign bus.update_flags = mask;
  assign bus.flags_in     = fin;
  assign bus.saved_flags  = saved_q;
  assign bus.saved_valid  = (state_q == ST_SAVE);
  assign bus.done         = (state_q == ST_CLR) || (state_q == ST_WRITE);

  trap_tracker u_trap_tracker (
    .clk            (clk),
    .reset_n        (reset_n),
    .entry_clr_i    (accept && (bus.cmd == CMD_ENTRY)),
    .tf_arm_i       ((state_q == ST_WRITE) && (cmd_q == CMD_RESTORE) &&
                     !bus.flags_cur[FLAG_TF] && data_q[FLAG_TF]),
    .sti_set_i      ((state_q == ST_WRITE) && (cmd_q == CMD_STI) &&
                     !bus.flags_cur[FLAG_IF]),
    .instr_done_i   (bus.instr_done),
    .trap_ack_i     (bus.trap_ack),
    .tf_cur_i       (bus.flags_cur[FLAG_TF]),
    .trap_pending_o (bus.trap_pending),
    .int_inhibit_o  (bus.int_inhibit)
  );

endmodule

// File: tb/tb_flags_sequencer.sv
// Directed scoreboard bench for flags_sequencer: expectations are queued as
// each step is driven and popped when the DUT output is sampled.
module tb_flags_sequencer;
  import flags_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  flags_sequencer_if bus ();

  flags_sequencer #(.FLAGS_RESET(16'h0002)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } ExpItem;

  ExpItem sbq[$];
  int     vectors     = 0;
  int     miscompares = 0;

  task automatic expectValue(input string tag, input logic [31:0] exp);
    ExpItem e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    ExpItem e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    e = sbq.pop_front();
    assert (obs === e.exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic checkNow(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expectValue(tag, exp);
    checkOutput(obs);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference for the write pulse of each command: mask, bits that matter, data.
  task automatic modelWrite(input FlagsCmd c, input logic [15:0] data, input logic [15:0] cur,
                            output logic [8:0] m, output logic [15:0] keep, output logic [15:0] fin);
    keep = 16'hFFFF;
    fin  = 16'h0000;
    m    = 9'h000;
    case (c)
      CMD_ENTRY:   begin m = 9'h060; fin = cur & 16'hFCFF; end
      CMD_RESTORE: begin m = 9'h1FF; fin = data | 16'h0002; end
      CMD_CLI:     begin m = 9'h040; keep = 16'h0200; fin = 16'h0000; end
      CMD_STI:     begin m = 9'h040; keep = 16'h0200; fin = 16'h0200; end
      CMD_CLD:     begin m = 9'h080; keep = 16'h0400; fin = 16'h0000; end
      CMD_STD:     begin m = 9'h080; keep = 16'h0400; fin = 16'h0400; end
      CMD_CLC:     begin m = 9'h001; keep = 16'h0001; fin = 16'h0000; end
      CMD_STC:     begin m = 9'h001; keep = 16'h0001; fin = 16'h0001; end
      CMD_CMC:     begin m = 9'h001; keep = 16'h0001; fin = {15'h0, ~cur[0]}; end
      default:     begin m = 9'h000; end
    endcase
  endtask

  // Presents one command for exactly one clock edge, starting just after an edge.
  task automatic applyStimulus(input FlagsCmd c, input logic [15:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.cmd_data  = data;
    nextCycle();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'h0000;
  endtask

  task automatic waitDone(output int lat);
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runCommand(input FlagsCmd c, input logic [15:0] data);
    logic [8:0]  m;
    logic [15:0] keep;
    logic [15:0] fin;
    int          lat;
    string       n;
    n = c.name();
    modelWrite(c, data, bus.flags_cur, m, keep, fin);
    if (c == CMD_ENTRY) expectValue({n, "_saved_valid"}, 32'd1);
    expectValue({n, "_latency"}, 32'd1);
    expectValue({n, "_ready_busy"}, 32'd0);
    expectValue({n, "_mask"}, {23'd0, m});
    expectValue({n, "_data"}, {16'd0, fin & keep});
    if (c == CMD_ENTRY) expectValue({n, "_saved_flags"}, {16'd0, bus.flags_cur});
    expectValue({n, "_ready_after"}, 32'd1);
    applyStimulus(c, data);
    if (c == CMD_ENTRY) begin
      @(negedge clk);
      checkOutput({31'd0, bus.saved_valid});
    end
    waitDone(lat);
    checkOutput(lat);
    checkOutput({31'd0, bus.cmd_ready});
    checkOutput({23'd0, bus.update_flags});
    checkOutput({16'd0, bus.flags_in & keep});
    if (c == CMD_ENTRY) checkOutput({16'd0, bus.saved_flags});
    nextCycle();
    checkOutput({31'd0, bus.cmd_ready});
  endtask

  task automatic pulseInstr(input logic idone, input logic ack);
    bus.instr_done = idone;
    bus.trap_ack   = ack;
    nextCycle();
    bus.instr_done = 1'b0;
    bus.trap_ack   = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    FlagsCmd     c;
    logic [15:0] cur;
  } SimpleOp;

  SimpleOp ops[5];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd        = CMD_ENTRY;
    bus.cmd_data   = 16'h0000;
    bus.flags_cur  = 16'h0302;
    bus.instr_done = 1'b0;
    bus.trap_ack   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkNow("rst_cmd_ready",    {31'd0, bus.cmd_ready},    32'd1);
    checkNow("rst_update_flags", {23'd0, bus.update_flags}, 32'd0);
    checkNow("rst_flags_in",     {16'd0, bus.flags_in},     32'd0);
    checkNow("rst_saved_flags",  {16'd0, bus.saved_flags},  32'h0002);
    checkNow("rst_saved_valid",  {31'd0, bus.saved_valid},  32'd0);
    checkNow("rst_done",         {31'd0, bus.done},         32'd0);
    checkNow("rst_trap_pending", {31'd0, bus.trap_pending}, 32'd0);
    checkNow("rst_int_inhibit",  {31'd0, bus.int_inhibit},  32'd0);
    nextCycle();

    runCommand(CMD_ENTRY, 16'h0000);

    bus.flags_cur = 16'h0303;
    runCommand(CMD_CMC, 16'h0000);
    bus.flags_cur = 16'h0302;
    runCommand(CMD_CMC, 16'h0000);

    ops[0] = '{CMD_CLI, 16'h0302};
    ops[1] = '{CMD_STD, 16'h0302};
    ops[2] = '{CMD_CLD, 16'h0702};
    ops[3] = '{CMD_STC, 16'h0302};
    ops[4] = '{CMD_CLC, 16'h0303};
    for (int i = 0; i < 5; i++) begin
      bus.flags_cur = ops[i].cur;
      runCommand(ops[i].c, 16'h0000);
    end

    bus.flags_cur = 16'h0002;
    runCommand(CMD_RESTORE, 16'h0FD5);
    bus.flags_cur = 16'h0FD7;
    pulseInstr(1'b1, 1'b0);
    checkNow("trap_after_first_retire",  {31'd0, bus.trap_pending}, 32'd0);
    nextCycle();
    pulseInstr(1'b1, 1'b0);
    checkNow("trap_after_second_retire", {31'd0, bus.trap_pending}, 32'd1);
    nextCycle();
    pulseInstr(1'b1, 1'b1);
    checkNow("trap_set_beats_ack",       {31'd0, bus.trap_pending}, 32'd1);
    nextCycle();
    pulseInstr(1'b0, 1'b1);
    checkNow("trap_ack_clears",          {31'd0, bus.trap_pending}, 32'd0);
    nextCycle();

    bus.flags_cur = 16'h0002;
    runCommand(CMD_STI, 16'h0000);
    checkNow("sti_shadow_set",  {31'd0, bus.int_inhibit}, 32'd1);
    nextCycle();
    checkNow("sti_shadow_held", {31'd0, bus.int_inhibit}, 32'd1);
    pulseInstr(1'b1, 1'b0);
    checkNow("sti_shadow_cleared", {31'd0, bus.int_inhibit},  32'd0);
    checkNow("no_trap_tf_clear",   {31'd0, bus.trap_pending}, 32'd0);
    nextCycle();
    bus.flags_cur = 16'h0202;
    runCommand(CMD_STI, 16'h0000);
    checkNow("sti_if_set_no_shadow", {31'd0, bus.int_inhibit}, 32'd0);

    bus.flags_cur = 16'h0B02;
    applyStimulus(CMD_ENTRY, 16'h0000);
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    @(negedge clk);
    checkNow("rsave_done",         {31'd0, bus.done},         32'd0);
    checkNow("rsave_update_flags", {23'd0, bus.update_flags}, 32'd0);
    checkNow("rsave_cmd_ready",    {31'd0, bus.cmd_ready},    32'd1);
    checkNow("rsave_saved_flags",  {16'd0, bus.saved_flags},  32'h0002);
    checkNow("rsave_saved_valid",  {31'd0, bus.saved_valid},  32'd0);
    nextCycle();
    @(negedge clk);
    checkNow("rsave_done_later",   {31'd0, bus.done},         32'd0);
    checkNow("rsave_mask_later",   {23'd0, bus.update_flags}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
